// File: rtl/matrix_pkg.sv
// Shared types and helpers for the streaming matrix add/subtract block.
// Holds mode codes, FSM encoding and width helpers.
package matrix_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  function automatic int clog2_min1(input int n);
    return ($clog2(n) < 1) ? 1 : $clog2(n);
  endfunction

  function automatic longint smax(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint smin(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/matrix_addsub_stream_if.sv
// Operand/result stream bundle for matrix_addsub_stream.
// slave = block side, master = fetch/sink side.
interface matrix_addsub_stream_if #(
  parameter int WIDTH = 16,
  parameter int ROWS  = 3,
  parameter int COLS  = 3
);
  import matrix_pkg::*;

  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);

  logic             mode_sub;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic [RW-1:0]    out_row;
  logic [CW-1:0]    out_col;
  logic             out_last;
  logic             out_ovf;

  modport slave (
    input  mode_sub, in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_sum,
    output out_row, out_col, out_last, out_ovf
  );

  modport master (
    output mode_sub, in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_sum,
    input  out_row, out_col, out_last, out_ovf
  );

endinterface

// File: rtl/matrix_addsub_stream_elem_addsub.sv
// Combinational signed add/subtract with overflow flag.
// MATRIX_SATURATE_EN clamps overflowed results to the signed range.
module elem_addsub
  import matrix_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

`ifdef MATRIX_SATURATE_EN
  localparam logic [WIDTH-1:0] SMAX = WIDTH'(smax(WIDTH));
  localparam logic [WIDTH-1:0] SMIN = WIDTH'(smin(WIDTH));
`endif

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] raw;

  always_comb begin
    // A-B is A + ~B + 1, so one adder covers both modes
    b_eff = sub ? ~b : b;
    raw   = a + b_eff + WIDTH'(sub);
    ovf   = (a[WIDTH-1] == b_eff[WIDTH-1]) &&
            (raw[WIDTH-1] != a[WIDTH-1]);
`ifdef MATRIX_SATURATE_EN
    if (ovf) sum = a[WIDTH-1] ? SMIN : SMAX;
    else     sum = raw;
`else
    sum = raw;
`endif
  end

endmodule

// File: rtl/matrix_addsub_stream.sv
// Streaming ROWS x COLS matrix add/subtract, one element per beat.
// Optional MATRIX_SATURATE_EN clamps element results on overflow.
module matrix_addsub_stream
  import matrix_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int ROWS  = 3,
  parameter int COLS  = 3
) (
  input  logic clk,
  input  logic rst,
  output logic busy,
  matrix_addsub_stream_if.slave s
);

  localparam int RW = clog2_min1(ROWS);
  localparam int CW = clog2_min1(COLS);
  localparam logic [RW-1:0] ROW_END = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_END = CW'(COLS - 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic [RW-1:0]    row_q, row_d;
  logic [CW-1:0]    col_q, col_d;
  logic             acc_q, acc_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_sum_q, out_sum_d;
  logic [RW-1:0]    out_row_q, out_row_d;
  logic [CW-1:0]    out_col_q, out_col_d;
  logic             out_last_q, out_last_d;
  logic             out_ovf_q, out_ovf_d;

  logic             accept;
  logic             first;
  logic             at_end;
  logic             mode_eff;
  logic             ovf_now;
  logic             elem_ovf;
  logic [WIDTH-1:0] elem_sum;

  assign s.in_ready = !rst && (!out_valid_q || s.out_ready);
  assign accept     = s.in_valid && s.in_ready;
  assign first      = (state_q == ST_IDLE);
  assign at_end     = (row_q == ROW_END) && (col_q == COL_END);
  assign mode_eff   = first ? s.mode_sub : mode_q;
  assign ovf_now    = (first ? 1'b0 : acc_q) | elem_ovf;

  elem_addsub #(.WIDTH(WIDTH)) u_elem (
    .a   (s.in_a),
    .b   (s.in_b),
    .sub (mode_eff == MODE_SUB),
    .sum (elem_sum),
    .ovf (elem_ovf)
  );

  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    row_d       = row_q;
    col_d       = col_q;
    acc_d       = acc_q;
    out_valid_d = out_valid_q;
    out_sum_d   = out_sum_q;
    out_row_d   = out_row_q;
    out_col_d   = out_col_q;
    out_last_d  = out_last_q;
    out_ovf_d   = out_ovf_q;
    if (accept) begin
      out_valid_d = 1'b1;
      out_sum_d   = elem_sum;
      out_row_d   = row_q;
      out_col_d   = col_q;
      out_last_d  = at_end;
      out_ovf_d   = ovf_now;
      acc_d       = ovf_now;
      mode_d      = mode_eff;
      state_d     = at_end ? ST_IDLE : ST_RUN;
      if (col_q == COL_END) begin
        col_d = '0;
        row_d = at_end ? '0 : row_q + RW'(1);
      end else begin
        col_d = col_q + CW'(1);
      end
    end else if (s.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_ADD;
      row_q       <= '0;
      col_q       <= '0;
      acc_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_row_q   <= '0;
      out_col_q   <= '0;
      out_last_q  <= 1'b0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      row_q       <= row_d;
      col_q       <= col_d;
      acc_q       <= acc_d;
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_row_q   <= out_row_d;
      out_col_q   <= out_col_d;
      out_last_q  <= out_last_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign s.out_valid = out_valid_q;
  assign s.out_sum   = out_sum_q;
  assign s.out_row   = out_row_q;
  assign s.out_col   = out_col_q;
  assign s.out_last  = out_last_q;
  assign s.out_ovf   = out_ovf_q;
  assign busy        = (state_q == ST_RUN);

endmodule

// File: tb/tb_matrix_addsub_stream.sv
// Randomised bench for matrix_addsub_stream against an integer model.
// Covers 3x3 default, plus 2x5 and 1x1/8-bit instances.
module tb_matrix_addsub_stream;

  logic clk = 1'b0;
  logic rst;
  logic busy, busy2, busy1;

  always #5 clk = ~clk;

  matrix_addsub_stream_if #(.WIDTH(16), .ROWS(3), .COLS(3)) m ();
  matrix_addsub_stream_if #(.WIDTH(16), .ROWS(2), .COLS(5)) m2 ();
  matrix_addsub_stream_if #(.WIDTH(8),  .ROWS(1), .COLS(1)) m1 ();

  matrix_addsub_stream #(.WIDTH(16), .ROWS(3), .COLS(3)) dut (
    .clk(clk), .rst(rst), .busy(busy), .s(m.slave));
  matrix_addsub_stream #(.WIDTH(16), .ROWS(2), .COLS(5)) dut2 (
    .clk(clk), .rst(rst), .busy(busy2), .s(m2.slave));
  matrix_addsub_stream #(.WIDTH(8), .ROWS(1), .COLS(1)) dut1 (
    .clk(clk), .rst(rst), .busy(busy1), .s(m1.slave));

  int n_chk = 0;
  int n_fail = 0;

  task automatic check(input string tag,
                       input logic [63:0] got,
                       input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               tag, got, exp, $time);
    end
  endtask

  // integer reference: exact result, range test, then wrap/clamp
  function automatic void ref_op(input int w, input int a, input int b,
                                 input bit sub, output int res,
                                 output bit ovf);
    longint r, hi, lo;
    hi = (longint'(1) << (w - 1)) - 1;
    lo = -hi - 1;
    r = sub ? longint'(a) - longint'(b) : longint'(a) + longint'(b);
    ovf = (r > hi) || (r < lo);
`ifdef MATRIX_SATURATE_EN
    if (ovf) r = (r > hi) ? hi : lo;
`endif
    res = int'(r & ((longint'(1) << w) - 1));
  endfunction

  function automatic int rnd_s(input int w);
    int u;
    u = int'($urandom_range(0, (1 << w) - 1));
    return (u >= (1 << (w - 1))) ? u - (1 << w) : u;
  endfunction

  // model of the 3x3 instance: element index within the matrix etc.
  int k;
  bit mmode, macc, mv, mlast, movf;
  int msum, mrow, mcol;

  task automatic model_reset();
    k = 0; mmode = 0; macc = 0; mv = 0;
    msum = 0; mrow = 0; mcol = 0; mlast = 0; movf = 0;
  endtask

  task automatic cyc(input bit v, input int a, input int b,
                     input bit md, input bit rdy, output bit acc);
    int res;
    bit ov;
    m.in_valid  = v;
    m.in_a      = a[15:0];
    m.in_b      = b[15:0];
    m.mode_sub  = md;
    m.out_ready = rdy;
    @(negedge clk);
    check("in_ready", 64'(m.in_ready), 64'(!mv || rdy));
    acc = v && (!mv || rdy);
    @(posedge clk);
    #1;
    if (acc) begin
      if (k == 0) begin
        mmode = md;
        macc  = 0;
      end
      ref_op(16, a, b, mmode, res, ov);
      macc  = macc | ov;
      mv    = 1;
      msum  = res;
      mrow  = k / 3;
      mcol  = k % 3;
      mlast = (k == 8);
      movf  = macc;
      k     = (k + 1) % 9;
    end else if (rdy) begin
      mv = 0;
    end
    check("out_valid", 64'(m.out_valid), 64'(mv));
    check("busy", 64'(busy), 64'(k != 0));
    if (mv) begin
      check("out_sum", 64'(m.out_sum), 64'(msum));
      check("out_row", 64'(m.out_row), 64'(mrow));
      check("out_col", 64'(m.out_col), 64'(mcol));
      check("out_last", 64'(m.out_last), 64'(mlast));
      check("out_ovf", 64'(m.out_ovf), 64'(movf));
    end
  endtask

  int A_ADD[9] = '{128, 16, 128, 8, 2, 1, 2, 16, 2};
  int B_ADD[9] = '{4, 2, 1, 1, 1, 1, 4, 512, 2};
  int E_ADD[9] = '{132, 18, 129, 9, 3, 2, 6, 528, 4};
  int A_SUB[9] = '{5, 100, -3, 0, 7, -32768, 1, 2, 3};
  int B_SUB[9] = '{7, 50, 4, 0, -9, 1, 9, 2, -3};

  initial begin
    bit acc, md, v, rdy;
    int i, guard, r, a2, b2, a1, b1, lm2;
    bit ov, md2, md1;
    logic [15:0] held;

    rst = 1'b1;
    m.in_valid = 0; m.in_a = 0; m.in_b = 0;
    m.mode_sub = 0; m.out_ready = 0;
    m2.in_valid = 0; m2.in_a = 0; m2.in_b = 0;
    m2.mode_sub = 0; m2.out_ready = 1;
    m1.in_valid = 0; m1.in_a = 0; m1.in_b = 0;
    m1.mode_sub = 0; m1.out_ready = 1;
    model_reset();
    #1;
    check("rst_valid", 64'(m.out_valid), 64'(0));
    check("rst_ready", 64'(m.in_ready), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_sum", 64'(m.out_sum), 64'(0));
    check("rst_tags", {m.out_row, m.out_col}, 64'(0));
    check("rst_flags", {m.out_last, m.out_ovf}, 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // fixed add matrix, sink always ready
    for (int j = 0; j < 9; j++) begin
      cyc(1, A_ADD[j], B_ADD[j], 0, 1, acc);
      check("add_sum", 64'(m.out_sum), 64'(E_ADD[j]));
      check("add_last", 64'(m.out_last), 64'(j == 8));
      check("add_ovf", 64'(m.out_ovf), 64'(0));
    end
    cyc(0, 0, 0, 0, 1, acc);

    // backpressure: three stalled cycles after beat 2
    i = 0; guard = 0;
    while (i < 9 && guard < 40) begin
      rdy = !(guard >= 3 && guard < 6);
      held = m.out_sum;
      cyc(1, A_ADD[i], B_ADD[i], 0, rdy, acc);
      if (!rdy) check("bp_hold", 64'(m.out_sum), 64'(held));
      if (acc) i++;
      guard++;
    end
    check("bp_done", 64'(i), 64'(9));
    cyc(0, 0, 0, 0, 1, acc);

    // subtract latched on beat 0, mode toggled mid-matrix
    for (int j = 0; j < 9; j++) begin
      md = (j == 0) ? 1'b1 : (j == 4) ? 1'b0 : 1'($urandom % 2);
      cyc(1, A_SUB[j], B_SUB[j], md, 1, acc);
      if (j == 0) check("sub_5m7", 64'(m.out_sum), 64'(16'hFFFE));
    end
    cyc(0, 0, 0, 0, 1, acc);

    // overflow on beat 2 sticks to the end of the matrix
    for (int j = 0; j < 9; j++) begin
      if (j == 2) cyc(1, 32'h7FFF, 1, 0, 1, acc);
      else cyc(1, j, j, 0, 1, acc);
`ifdef MATRIX_SATURATE_EN
      if (j == 2) check("ovf_sum", 64'(m.out_sum), 64'(16'h7FFF));
`else
      if (j == 2) check("ovf_sum", 64'(m.out_sum), 64'(16'h8000));
`endif
      check("ovf_flag", 64'(m.out_ovf), 64'(j >= 2));
    end
    cyc(1, 3, 4, 0, 1, acc);
    check("ovf_clear", 64'(m.out_ovf), 64'(0));
    for (int j = 1; j < 9; j++) cyc(1, j, 1, 0, 1, acc);

    // random traffic with random valid and backpressure
    for (int c = 0; c < 300; c++) begin
      v   = ($urandom % 4) != 0;
      rdy = ($urandom % 4) != 0;
      cyc(v, rnd_s(16), rnd_s(16), 1'($urandom % 2), rdy, acc);
    end
    guard = 0;
    while (k != 0 && guard < 50) begin
      cyc(1, rnd_s(16), rnd_s(16), 0, 1, acc);
      guard++;
    end
    check("drain", 64'(k), 64'(0));
    cyc(0, 0, 0, 0, 1, acc);

    // asynchronous reset after four beats
    for (int j = 0; j < 4; j++) cyc(1, j, 2, 1, 1, acc);
    m.in_valid = 0;
    #2 rst = 1'b1;
    #1;
    check("mrst_valid", 64'(m.out_valid), 64'(0));
    check("mrst_busy", 64'(busy), 64'(0));
    check("mrst_ready", 64'(m.in_ready), 64'(0));
    #2 rst = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    cyc(1, 10, 3, 0, 1, acc);
    check("mrst_tag", {m.out_row, m.out_col}, 64'(0));
    check("mrst_sum", 64'(m.out_sum), 64'(13));
    for (int j = 1; j < 9; j++) cyc(1, j, j, 1, 1, acc);
    cyc(0, 0, 0, 0, 1, acc);

    // 2x5 and 1x1/8-bit instances at full throughput
    lm2 = 0;
    for (int j = 0; j < 20; j++) begin
      a2 = rnd_s(16); b2 = rnd_s(16); md2 = 1'($urandom % 2);
      a1 = rnd_s(8);  b1 = rnd_s(8);  md1 = 1'($urandom % 2);
      m2.in_valid = 1; m2.in_a = a2[15:0]; m2.in_b = b2[15:0];
      m2.mode_sub = md2;
      m1.in_valid = 1; m1.in_a = a1[7:0]; m1.in_b = b1[7:0];
      m1.mode_sub = md1;
      @(posedge clk);
      #1;
      if (j % 10 == 0) lm2 = int'(md2);
      ref_op(16, a2, b2, lm2[0], r, ov);
      check("s25_sum", 64'(m2.out_sum), 64'(r));
      check("s25_row", 64'(m2.out_row), 64'((j % 10) / 5));
      check("s25_col", 64'(m2.out_col), 64'(j % 5));
      check("s25_last", 64'(m2.out_last), 64'(j % 10 == 9));
      check("s25_busy", 64'(busy2), 64'(j % 10 != 9));
      ref_op(8, a1, b1, md1, r, ov);
      check("s11_sum", 64'(m1.out_sum), 64'(r));
      check("s11_ovf", 64'(m1.out_ovf), 64'(ov));
      check("s11_last", 64'(m1.out_last), 64'(1));
      check("s11_busy", 64'(busy1), 64'(0));
    end
    m2.in_valid = 0;
    m1.in_valid = 0;
    @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
